// File: rtl/sim_bus_pkg.sv
// Shared types and idle-bus constants for the simulator-side 6510 bus agents.
// The state enum is shared so every agent decodes bus progress the same way.
package sim_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PHI,
        ACTIVE,
        DONE
    } bus_state_e;

    // Value the data bus floats to when nobody drives it.
    localparam logic [7:0] BUS_IDLE_DATA     = 8'hFF;
    localparam logic [3:0] COLOR_NIBBLE_IDLE = 4'hF;

endpackage

// File: rtl/phi_phase_tracker.sv
// Finds phi edges in the dot4x domain and counts dot4x cycles into phi-high.
// The phase count saturates so a stretched phi-high cannot wrap it.
module phi_phase_tracker #(
    parameter int PHI_HALF = 16
) (
    input  logic                            clk_dot4x,
    input  logic                            rst,
    input  logic                            clk_phi,
    output logic                            phi_rise,
    output logic                            phi_fall,
    output logic [$clog2(PHI_HALF+1)-1:0]   phase
);

    localparam int PW = $clog2(PHI_HALF + 1);
    localparam logic [PW-1:0] PHASE_MAX = PW'(PHI_HALF);

    logic          phi_q;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign phi_rise = clk_phi & ~phi_q;
    assign phi_fall = ~clk_phi & phi_q;
    assign phase    = phase_q;

    always_comb begin
        phase_d = phase_q;
        if (phi_rise) begin
            phase_d = '0;
        end else if (clk_phi && (phase_q < PHASE_MAX)) begin
            phase_d = phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            phi_q   <= 1'b0;
            phase_q <= '0;
        end else begin
            phi_q   <= clk_phi;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/sim_cpu_bus_master.sv
// Simulator-only 6510-side initiator: turns request/response handshakes into
// phi2-aligned VIC-II register reads and writes on ce/rw/adl/dbl.
module sim_cpu_bus_master
    import sim_bus_pkg::*;
#(
    parameter int PHI_HALF     = 16,
    parameter int SAMPLE_AT    = 12,
    parameter int BA_STALL_MAX = 255
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic       clk_phi,
    input  logic       aec,
    input  logic       ba,
    input  logic [7:0] dbo_sim,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_abort,
    output logic       ce,
    output logic       rw,
    output logic [5:0] adl,
    output logic [7:0] dbl,
    output logic [3:0] dbh
);

    localparam int PW = $clog2(PHI_HALF + 1);
    localparam logic [PW-1:0] SAMPLE_PHASE = PW'(SAMPLE_AT);
    localparam logic [7:0]    STALL_LIMIT  = 8'(BA_STALL_MAX);

    logic          phi_rise;
    logic          phi_fall;
    logic [PW-1:0] phase;

    phi_phase_tracker #(
        .PHI_HALF (PHI_HALF)
    ) u_phase (
        .clk_dot4x (clk_dot4x),
        .rst       (rst),
        .clk_phi   (clk_phi),
        .phi_rise  (phi_rise),
        .phi_fall  (phi_fall),
        .phase     (phase)
    );

    bus_state_e state_q, state_d;
    logic       write_q, write_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] stall_q, stall_d;
    logic       abort_q, abort_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ce_q, ce_d;
    logic       rw_q, rw_d;
    logic [5:0] adl_q, adl_d;
    logic [7:0] dbl_q, dbl_d;
    logic [7:0] stall_inc;

    assign stall_inc = stall_q + 8'd1;

    // A request taken in IDLE only arms WAIT_PHI, so a rise coinciding with
    // acceptance is skipped and the access starts on the following rise.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stall_d = stall_q;
        abort_d = abort_q;
        rdata_d = rdata_q;
        ce_d    = ce_q;
        rw_d    = rw_q;
        adl_d   = adl_q;
        dbl_d   = dbl_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    stall_d = 8'd0;
                    abort_d = 1'b0;
                    rdata_d = BUS_IDLE_DATA;
                    state_d = WAIT_PHI;
                end
            end

            WAIT_PHI: begin
                // Writes never honour ba: the 6510 only stops on RDY during reads.
                if (phi_rise && aec) begin
                    if (write_q || ba) begin
                        ce_d    = 1'b0;
                        rw_d    = ~write_q;
                        adl_d   = addr_q;
                        dbl_d   = write_q ? wdata_q : BUS_IDLE_DATA;
                        state_d = ACTIVE;
                    end else begin
                        stall_d = stall_inc;
                        if (stall_inc == STALL_LIMIT) begin
                            abort_d = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end

            ACTIVE: begin
                // If phi falls before the sample point, rdata keeps its idle value.
                if (phi_fall) begin
                    ce_d    = 1'b1;
                    rw_d    = 1'b1;
                    dbl_d   = BUS_IDLE_DATA;
                    state_d = DONE;
                end else if (!write_q && (phase == SAMPLE_PHASE)) begin
                    rdata_d = dbo_sim;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= 6'd0;
            wdata_q <= BUS_IDLE_DATA;
            stall_q <= 8'd0;
            abort_q <= 1'b0;
            rdata_q <= BUS_IDLE_DATA;
            ce_q    <= 1'b1;
            rw_q    <= 1'b1;
            adl_q   <= 6'd0;
            dbl_q   <= BUS_IDLE_DATA;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            stall_q <= stall_d;
            abort_q <= abort_d;
            rdata_q <= rdata_d;
            ce_q    <= ce_d;
            rw_q    <= rw_d;
            adl_q   <= adl_d;
            dbl_q   <= dbl_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == DONE);
    assign rsp_abort = (state_q == DONE) && abort_q;
    assign rsp_rdata = rdata_q;
    assign ce        = ce_q;
    assign rw        = rw_q;
    assign adl       = adl_q;
    assign dbl       = dbl_q;
    assign dbh       = COLOR_NIBBLE_IDLE;

endmodule

// File: tb/tb_sim_cpu_bus_master.sv
// Directed bench for sim_cpu_bus_master against a tiny VIC register model.
// Built with a stall limit of 4 so the abort path is reachable quickly.
module tb_sim_cpu_bus_master;

    logic       clk_dot4x = 1'b0;
    logic       rst       = 1'b1;
    logic       clk_phi   = 1'b0;
    logic       aec       = 1'b1;
    logic       ba        = 1'b1;
    logic [7:0] dbo_sim;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [5:0] req_addr  = 6'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_abort;
    logic       ce;
    logic       rw;
    logic [5:0] adl;
    logic [7:0] dbl;
    logic [3:0] dbh;

    int assertCount = 0;
    int failCount   = 0;

    sim_cpu_bus_master #(
        .PHI_HALF     (16),
        .SAMPLE_AT    (12),
        .BA_STALL_MAX (4)
    ) dut (
        .clk_dot4x (clk_dot4x),
        .rst       (rst),
        .clk_phi   (clk_phi),
        .aec       (aec),
        .ba        (ba),
        .dbo_sim   (dbo_sim),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_abort (rsp_abort),
        .ce        (ce),
        .rw        (rw),
        .adl       (adl),
        .dbl       (dbl),
        .dbh       (dbh)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    // phi toggles on dot4x falling edges: 16 dot4x cycles per half period.
    initial begin
        forever begin
            repeat (16) @(negedge clk_dot4x);
            clk_phi = ~clk_phi;
        end
    end

    int riseTotal = 0;
    always @(posedge clk_phi) riseTotal++;

    // VIC register model; the border colour register keeps only its low nibble.
    logic [7:0] vicRegs [64];
    initial begin
        for (int i = 0; i < 64; i++) vicRegs[i] = 8'h00;
        vicRegs[6'h12] = 8'h80;
        forever begin
            @(posedge clk_dot4x);
            if (ce === 1'b0 && rw === 1'b0)
                vicRegs[adl] = (adl == 6'h20) ? {4'h0, dbl[3:0]} : dbl;
        end
    end

    // Bus monitor: length of each ce-low stretch and the bus state when it began.
    int         ceLowCnt    = 0;
    int         ceFallTotal = 0;
    int         riseAtCeLow = 0;
    int         rspTotal    = 0;
    bit         prevCeLow   = 1'b0;
    logic       rwAtLow;
    logic [5:0] adlAtLow;
    logic [7:0] dblAtLow;
    always @(negedge clk_dot4x) begin
        if (ce === 1'b0) begin
            ceLowCnt = prevCeLow ? ceLowCnt + 1 : 1;
            if (!prevCeLow) begin
                ceFallTotal++;
                riseAtCeLow = riseTotal;
                rwAtLow     = rw;
                adlAtLow    = adl;
                dblAtLow    = dbl;
            end
        end
        prevCeLow = (ce === 1'b0);
        if (rsp_valid === 1'b1) rspTotal++;
    end

    // Data is valid only around the DUT edge where its phase register reads 12
    // (13th dot4x edge of ce low); elsewhere the bus carries junk.
    assign dbo_sim = (ce === 1'b0 && ceLowCnt == 13) ? vicRegs[adl] : 8'h5A;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    int riseBase  = 0;
    int fallBase  = 0;
    int rspRise   = 0;
    logic [7:0] rspRdataSeen;
    logic       rspAbortSeen;
    logic       ceAtRsp;
    logic [5:0] adlAtRsp;

    task automatic applyStimulus(input logic wr, input logic [5:0] a,
                                 input logic [7:0] d, input bit alignFall);
        int n;
        if (alignFall) begin
            @(negedge clk_phi);
            repeat (3) @(negedge clk_dot4x);
        end else begin
            @(negedge clk_dot4x);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk_dot4x);
            n++;
        end
        if (req_ready !== 1'b1) checkOutput("req_ready_timeout", req_ready, 1);
        @(posedge clk_dot4x);
        riseBase = riseTotal;
        fallBase = ceFallTotal;
        @(negedge clk_dot4x);
        req_valid = 1'b0;
    endtask

    task automatic waitRsp(input string tag, input int budget);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < budget) begin
            @(negedge clk_dot4x);
            n++;
        end
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 1);
        rspRdataSeen = rsp_rdata;
        rspAbortSeen = rsp_abort;
        ceAtRsp      = ce;
        adlAtRsp     = adl;
        rspRise      = riseTotal;
        @(negedge clk_dot4x);
        checkOutput({tag, "_rsp_pulse"}, rsp_valid, 0);
        checkOutput({tag, "_ready_back"}, req_ready, 1);
    endtask

    task automatic waitRises(input int count);
        int n;
        n = 0;
        while ((riseTotal - riseBase) < count && n < 1000) begin
            @(negedge clk_dot4x);
            n++;
        end
        if ((riseTotal - riseBase) < count) checkOutput("rise_timeout", riseTotal - riseBase, count);
        repeat (4) @(negedge clk_dot4x);
    endtask

    int firstRise;
    int rspBefore;
    int n;

    initial begin
        // Reset state while rst is held.
        repeat (4) @(negedge clk_dot4x);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_ce", ce, 1);
        checkOutput("rst_rw", rw, 1);
        checkOutput("rst_adl", adl, 6'h00);
        checkOutput("rst_dbl", dbl, 8'hFF);
        checkOutput("rst_dbh", dbh, 4'hF);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 8'hFF);
        checkOutput("rst_rsp_abort", rsp_abort, 0);
        rst = 1'b0;
        @(negedge clk_dot4x);
        checkOutput("post_rst_ready", req_ready, 1);

        // Write 0x1B to the border colour register.
        applyStimulus(1'b1, 6'h20, 8'h1B, 1'b1);
        waitRsp("wr", 400);
        checkOutput("wr_rise", riseAtCeLow - riseBase, 1);
        checkOutput("wr_rw", rwAtLow, 0);
        checkOutput("wr_adl", adlAtLow, 6'h20);
        checkOutput("wr_dbl", dblAtLow, 8'h1B);
        checkOutput("wr_ce_len", ceLowCnt, 16);
        checkOutput("wr_ce_at_rsp", ceAtRsp, 1);
        checkOutput("wr_adl_held", adlAtRsp, 6'h20);
        checkOutput("wr_rdata", rspRdataSeen, 8'hFF);
        checkOutput("wr_abort", rspAbortSeen, 0);
        checkOutput("wr_border", vicRegs[6'h20], 8'h0B);

        // Read the raster register.
        applyStimulus(1'b0, 6'h12, 8'h00, 1'b1);
        waitRsp("rd", 400);
        checkOutput("rd_rdata", rspRdataSeen, 8'h80);
        checkOutput("rd_rw", rwAtLow, 1);
        checkOutput("rd_dbl", dblAtLow, 8'hFF);
        checkOutput("rd_ce_len", ceLowCnt, 16);
        checkOutput("rd_abort", rspAbortSeen, 0);

        // Read back the border colour.
        applyStimulus(1'b0, 6'h20, 8'h00, 1'b1);
        waitRsp("rdb", 400);
        checkOutput("rdb_rdata", rspRdataSeen, 8'h0B);

        // ba low for three rises, then released: access on the fourth.
        ba = 1'b0;
        applyStimulus(1'b0, 6'h12, 8'h00, 1'b1);
        waitRises(3);
        checkOutput("stall_no_ce", ceFallTotal - fallBase, 0);
        ba = 1'b1;
        waitRsp("stall", 400);
        checkOutput("stall_rise", riseAtCeLow - riseBase, 4);
        checkOutput("stall_abort", rspAbortSeen, 0);
        checkOutput("stall_rdata", rspRdataSeen, 8'h80);

        // aec low rises do not count toward the stall limit.
        aec = 1'b0;
        ba  = 1'b0;
        applyStimulus(1'b0, 6'h20, 8'h00, 1'b1);
        waitRises(2);
        aec = 1'b1;
        waitRises(5);
        checkOutput("aec_no_ce", ceFallTotal - fallBase, 0);
        ba = 1'b1;
        waitRsp("aec", 400);
        checkOutput("aec_rise", riseAtCeLow - riseBase, 6);
        checkOutput("aec_abort", rspAbortSeen, 0);
        checkOutput("aec_rdata", rspRdataSeen, 8'h0B);

        // ba held low: abort after the fourth rise, bus never driven.
        ba = 1'b0;
        applyStimulus(1'b0, 6'h12, 8'h00, 1'b1);
        waitRsp("abort", 400);
        checkOutput("abort_flag", rspAbortSeen, 1);
        checkOutput("abort_rdata", rspRdataSeen, 8'hFF);
        checkOutput("abort_rise", rspRise - riseBase, 4);
        checkOutput("abort_no_ce", ceFallTotal - fallBase, 0);

        // Writes ignore ba.
        applyStimulus(1'b1, 6'h21, 8'h05, 1'b1);
        waitRsp("wrba", 400);
        checkOutput("wrba_rise", riseAtCeLow - riseBase, 1);
        checkOutput("wrba_rw", rwAtLow, 0);
        checkOutput("wrba_data", vicRegs[6'h21], 8'h05);
        ba = 1'b1;

        // Reset during ACTIVE kills the transaction silently.
        applyStimulus(1'b0, 6'h12, 8'h00, 1'b1);
        n = 0;
        while (ce !== 1'b0 && n < 200) begin
            @(negedge clk_dot4x);
            n++;
        end
        checkOutput("kill_ce_low", ce, 0);
        repeat (3) @(negedge clk_dot4x);
        rspBefore = rspTotal;
        rst = 1'b1;
        @(negedge clk_dot4x);
        checkOutput("kill_ce", ce, 1);
        checkOutput("kill_rw", rw, 1);
        checkOutput("kill_dbl", dbl, 8'hFF);
        checkOutput("kill_rsp_valid", rsp_valid, 0);
        checkOutput("kill_req_ready", req_ready, 0);
        repeat (3) @(negedge clk_dot4x);
        rst = 1'b0;
        repeat (40) @(negedge clk_dot4x);
        checkOutput("kill_no_rsp", rspTotal - rspBefore, 0);

        // Back-to-back read then write in consecutive phi cycles.
        applyStimulus(1'b0, 6'h12, 8'h00, 1'b1);
        waitRsp("b2b_rd", 400);
        checkOutput("b2b_rd_rdata", rspRdataSeen, 8'h80);
        firstRise = riseAtCeLow;
        applyStimulus(1'b1, 6'h22, 8'h3C, 1'b0);
        waitRsp("b2b_wr", 400);
        checkOutput("b2b_consecutive", riseAtCeLow - firstRise, 1);
        checkOutput("b2b_wr_data", vicRegs[6'h22], 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sim_cpu_bus_master.md
Name: sim_cpu_bus_master

Overview:
- Simulator-only 6510-side bus initiator. It sequences register reads and writes onto the VIC-II CPU-facing pins (ce, rw, adl, dbl/dbh) and captures read data from dbo_sim.
- It sits in the simulator top beside the vicii instance, clocked by the dot clock.
- It lets directed benches and the C++ harness poke VIC registers with real phi2-aligned timing instead of forcing pins.

Parameters:
- PHI_HALF, 16, dot4x cycles per phi half-period (32 per phi cycle).
- SAMPLE_AT, 12, dot4x cycles after phi rise at which read data is captured (1..PHI_HALF-1).
- BA_STALL_MAX, 255, maximum phi cycles a read may stall on ba low before being aborted.

Ports:
- clk_dot4x  in  1  dot clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_phi  in  1  phi clock from vicii, sampled in the clk_dot4x domain.
- aec  in  1  high means the CPU may own the bus in the phi-high phase.
- ba  in  1  low means the VIC is requesting the bus (RDY low).
- dbo_sim  in  8  VIC data out, sampled on reads.
- req_valid  in  1  request strobe.
- req_ready  out  1  high when a request is accepted.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  6  register address (0x00-0x3F).
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse on completion.
- rsp_rdata  out  8  read data; 0xFF on writes and aborts.
- rsp_abort  out  1  qualifies rsp_valid; 1 = read aborted on stall limit.
- ce  out  1  chip enable to vicii, active low.
- rw  out  1  1 = read, 0 = write.
- adl  out  6  address to vicii.
- dbl  out  8  data to vicii.
- dbh  out  4  colour nibble to vicii; always 0xF.

Behaviour:
- Reset values: ce=1, rw=1, adl=0, dbl=0xFF, dbh=0xF, req_ready=0 during rst and 1 the cycle after, rsp_valid=0, rsp_rdata=0xFF, rsp_abort=0, state=IDLE.
- Edge detect: phi_q is a registered clk_phi; phi_rise = clk_phi & ~phi_q; phi_fall = ~clk_phi & phi_q.
- Phase counter: reset to 0 on phi_rise, increments while clk_phi is high, saturates at PHI_HALF.
- IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata, drop req_ready, go to WAIT_PHI.
- WAIT_PHI, rise with aec=1 and (write or ba=1): drive ce=0, rw=~write, adl=addr, dbl=wdata for writes (0xFF for reads), go to ACTIVE.
- WAIT_PHI, rise with a read and ba=0: increment the stall counter and stay. When the counter reaches BA_STALL_MAX, pulse rsp_valid with rsp_abort=1, then go to IDLE.
- WAIT_PHI, rise with aec=0: stay; the counter is not incremented.
- Writes ignore ba, matching 6510 RDY semantics.
- ACTIVE: capture rsp_rdata <= dbo_sim at phase counter == SAMPLE_AT, reads only. On phi_fall: ce=1, rw=1, dbl=0xFF, adl held; go to DONE.
- ACTIVE, phi_fall before SAMPLE_AT is reached (malformed clock): rsp_rdata=0xFF, complete normally.
- DONE: rsp_valid=1 for one cycle (rsp_rdata=0xFF for writes), go to IDLE. req_ready reasserts the following cycle, so at most one transaction per phi cycle.
- A request accepted in the same cycle as phi_rise waits for the next rise. The latch happens in that cycle, and the transition is evaluated from WAIT_PHI only.
- rst mid-transaction: all outputs return to reset values next cycle. No rsp_valid is emitted for the killed transaction.
- Stall counter: 8 bits, cleared on entry to WAIT_PHI.

Decomposition:
- Shared package sim_bus_pkg: state enum (IDLE, WAIT_PHI, ACTIVE, DONE) and constants BUS_IDLE_DATA=8'hFF and COLOR_NIBBLE_IDLE=4'hF.
- Sub-module phi_phase_tracker: edge detect plus saturating phase counter, outputs phi_rise/phi_fall/phase. Reusable by other sim bus agents.

Test Plan:
- Write 0x1B to addr 0x20 with aec=1, ba=1 -> at the next phi rise ce=0, rw=0, adl=0x20, dbl=0x1B; ce=1 exactly at phi fall; rsp_valid pulses 1 cycle later with rsp_rdata=0xFF; the VIC border colour register reads 0xB (the vicii keeps only the low nibble of 0x1B).
- Read addr 0x12 with raster=0x80 -> rsp_rdata=0x80 captured at phase 12; ce is low for exactly 16 dot4x cycles.
- Read with ba=0 for 3 phi cycles then ba=1 -> ce stays 1 for 3 rises and asserts on the 4th; rsp_abort=0.
- BA_STALL_MAX=4, read with ba held 0 -> rsp_valid with rsp_abort=1 after the 4th rise; ce never asserted.
- Write with ba=0, aec=1 -> proceeds on the first rise (no stall).
- Assert rst during ACTIVE -> next cycle ce=1, rw=1, dbl=0xFF, rsp_valid=0, req_ready=0 while rst is high; after release, a back-to-back read/write pair completes in consecutive phi cycles.
